// File: rtl/blade_pkg.sv
// Shared definitions for the lightsaber blade PWM stage.
// Holds the blade state encodings and the brightness / PWM end points
// used by the top-level sequencer and the per-colour PWM channels.
package blade_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_IGNITE  = 2'd1,
    ST_ON      = 2'd2,
    ST_RETRACT = 2'd3
  } blade_state_e;

  localparam logic [7:0] LEVEL_MAX = 8'd255;
  localparam logic [7:0] PWM_TOP   = 8'd255;

endpackage

// File: rtl/pwm_channel.sv
// One colour channel of the blade LED driver.
// Scales the colour value by (level+1)/256 and latches the result as the
// duty cycle once per PWM period, then compares it against the shared
// period counter.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   load     high on the last count of a PWM period (duty reload edge)
//   colour   8-bit colour value
//   level    8-bit current brightness
//   pwm_cnt  shared free-running period counter
//   led      PWM drive, high while pwm_cnt < duty
module pwm_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] colour,
  input  logic [7:0] level,
  input  logic [7:0] pwm_cnt,
  output logic       led
);

  logic [7:0] duty_q;
  logic [7:0] duty_next;

  // (level+1) makes level 255 an exact unity gain; upper product byte is the duty.
  assign duty_next = 8'((16'(colour) * (16'(level) + 16'd1)) >> 8);

  // Duty only moves at the period boundary so a mid-period change never
  // produces a runt pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= 8'd0;
    end else if (load) begin
      duty_q <= duty_next;
    end
  end

  assign led = (pwm_cnt < duty_q);

endmodule

// File: rtl/lightsaber_blade_pwm.sv
// Blade ignition/retraction sequencer and RGB PWM driver.
// Ramps the brightness level up while en is held and down when it drops,
// then drives three PWM outputs whose duty is the colour scaled by level.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         blade-on request
//   r_in/g_in/b_in  8-bit colour values
//   led_r/led_g/led_b  PWM drives
//   level      current brightness 0..255
//   state      blade state (OFF/IGNITE/ON/RETRACT)
//   blade_on   high while fully lit
//
// state    | meaning
// OFF      | dark, level 0, waiting for en
// IGNITE   | level climbing one step every RAMP_DIV cycles
// ON       | fully lit, level 255
// RETRACT  | level falling one step every RAMP_DIV cycles
module lightsaber_blade_pwm
  import blade_pkg::*;
#(
  parameter int RAMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [7:0] level,
  output logic [1:0] state,
  output logic       blade_on
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  blade_state_e  state_q, state_d;
  logic [7:0]    level_q, level_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [RW-1:0] ramp_adv;
  logic          ramp_tc;
  logic [7:0]    pwm_cnt_q;
  logic          load;

  assign ramp_tc  = (ramp_q == RAMP_LAST);
  assign ramp_adv = ramp_tc ? '0 : ramp_q + RW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      level_q   <= 8'd0;
      ramp_q    <= '0;
      pwm_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      ramp_q    <= ramp_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  // Reversals hold the level but let the step timer keep running, so the
  // first step in the new direction lands on the existing step cadence.
  // The end-point guards keep a reversal at 0 or 255 from wrapping level.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ramp_d  = ramp_q;
    unique case (state_q)
      ST_OFF: begin
        ramp_d = '0;
        if (en) state_d = ST_IGNITE;
      end
      ST_IGNITE: begin
        if (!en) begin
          state_d = ST_RETRACT;
          ramp_d  = ramp_adv;
        end else if (level_q == LEVEL_MAX) begin
          state_d = ST_ON;
          ramp_d  = '0;
        end else begin
          ramp_d = ramp_adv;
          if (ramp_tc) begin
            level_d = level_q + 8'd1;
            if (level_q == LEVEL_MAX - 8'd1) state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        ramp_d = '0;
        if (!en) state_d = ST_RETRACT;
      end
      ST_RETRACT: begin
        if (en) begin
          state_d = ST_IGNITE;
          ramp_d  = ramp_adv;
        end else if (level_q == 8'd0) begin
          state_d = ST_OFF;
          ramp_d  = '0;
        end else begin
          ramp_d = ramp_adv;
          if (ramp_tc) begin
            level_d = level_q - 8'd1;
            if (level_q == 8'd1) state_d = ST_OFF;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    blade_on = (state_q == ST_ON);
    state    = state_q;
    level    = level_q;
  end

  assign load = (pwm_cnt_q == PWM_TOP);

  pwm_channel u_ch_r (
    .clk(clk), .rst(rst), .load(load), .colour(r_in),
    .level(level_q), .pwm_cnt(pwm_cnt_q), .led(led_r)
  );

  pwm_channel u_ch_g (
    .clk(clk), .rst(rst), .load(load), .colour(g_in),
    .level(level_q), .pwm_cnt(pwm_cnt_q), .led(led_g)
  );

  pwm_channel u_ch_b (
    .clk(clk), .rst(rst), .load(load), .colour(b_in),
    .level(level_q), .pwm_cnt(pwm_cnt_q), .led(led_b)
  );

endmodule

// File: doc/lightsaber_blade_pwm.md
Name: lightsaber_blade_pwm

Overview:
Downstream consumer of the lightsaber colour registers. Takes the registered 8-bit R/G/B values and the power enable, and runs the blade ignition and retraction brightness ramp. Scales each colour by the current brightness level and drives three 8-bit PWM LED outputs. This is the last stage before the physical RGB LED pins.

Parameters:
RAMP_DIV, 4, clock cycles per brightness step (>=1); full ignite or retract from an end point takes 255*RAMP_DIV cycles

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  power / blade-on request (the colour registers' enable)
r_in  input  8  red colour value from colour registers
g_in  input  8  green colour value from colour registers
b_in  input  8  blue colour value from colour registers
led_r  output  1  red PWM drive
led_g  output  1  green PWM drive
led_b  output  1  blue PWM drive
level  output  8  current brightness level, 0..255
state  output  2  blade state: OFF=0, IGNITE=1, ON=2, RETRACT=3
blade_on  output  1  1 iff state==ON

Behaviour:
- Reset is synchronous and active-high; it applies at the clk edge where rst=1 and overrides all other inputs.
- Reset values: state=OFF, level=0, ramp_cnt=0, pwm_cnt=0, duty_r/g/b=0, led_r/g/b=0, blade_on=0.
- State transitions, evaluated every edge:
  - OFF: en=1 -> IGNITE; otherwise stay OFF.
  - IGNITE: en=0 -> RETRACT, level held. Otherwise, when ramp_cnt==RAMP_DIV-1: level<=level+1 and ramp_cnt<=0; if level+1==255, go to ON on the same edge. Otherwise ramp_cnt<=ramp_cnt+1.
  - ON: en=0 -> RETRACT; level stays 255.
  - RETRACT: en=1 -> IGNITE, level held. Otherwise, when ramp_cnt==RAMP_DIV-1: level<=level-1 and ramp_cnt<=0; if level-1==0, go to OFF on the same edge.
- ramp_cnt is forced to 0 in OFF and ON. On a direction reversal it is not cleared and keeps counting.
- Level never wraps; it saturates at the 0 and 255 end points by construction.
- pwm_cnt is an 8-bit free-running counter from reset: 0..255, then wraps to 0. The PWM period is 256 cycles.
- Duty update: only on the edge where pwm_cnt==255 is duty_x loaded with (x_in * (level+1)) >> 8.
  - The product is 16-bit unsigned; take bits [15:8].
  - level=0 gives duty 0; level=255 gives duty exactly x_in.
  - Colour or level changes mid-period take effect at the next period only, so there are no glitch pulses.
- led_x = (pwm_cnt < duty_x), decoded directly from registers.
  - Duty 0: output always low.
  - Duty 255: output high for 255 of 256 cycles.
- en pulse of one cycle while OFF: goes OFF->IGNITE->RETRACT and returns to OFF. Level reaches at most 1.
- Reset asserted mid-IGNITE, mid-ON or mid-RETRACT: immediate return to reset values on that edge, with no ramp-down.

Decomposition:
- Shared package blade_pkg holds:
  - state encodings ST_OFF=2'd0, ST_IGNITE=2'd1, ST_ON=2'd2, ST_RETRACT=2'd3
  - LEVEL_MAX=8'd255
  - PWM_TOP=8'd255
- Sub-module pwm_channel is instantiated 3x. It holds the duty register, the scale multiply and the compare.
  - Inputs: clk, rst, load (pwm_cnt==PWM_TOP), colour[7:0], level[7:0], pwm_cnt[7:0].
  - Output: led.
- Top level holds the FSM, ramp_cnt, level and pwm_cnt.

Test Plan:
- Reset check: assert rst for 2 cycles with en=1 -> state=0, level=0, all leds=0 and blade_on=0 on the cycle after the rst edge.
- Full ignition: RAMP_DIV=1, en=1, r=255, g=128, b=0 -> state=IGNITE on cycle 1; level=255 and state=ON after 255 further edges; blade_on=1. In the next full PWM period, led_r is high 255 cycles, led_g high 128 cycles, led_b high 0 cycles.
- Retract reversal: RAMP_DIV=4, ignite until level=100, drop en -> state=RETRACT and level holds 100 on the transition edge, then decrements every 4 cycles. Reassert en at level=90 -> IGNITE, level climbs from 90.
- Scaling: level=127 (held via en toggling), r=200 -> duty_r=(200*128)>>8=100, giving 100 high cycles per period. Level 0 with r=255 -> led_r never high.
- Mid-period colour change: in ON, change g from 40 to 200 at pwm_cnt=10 -> the current period still shows 40 high cycles; the next period shows 200.
- Reset mid-ON: pulse rst while ON with r=255 -> next cycle state=OFF, level=0, led_r=0. With en still 1 after reset releases, ignition restarts from level 0.
